// File: rtl/bp_be_idiv_radix2.sv
// Iterative radix-2 restoring divider with RISC-V M-extension result semantics.
// One operation in flight; results are held until the requester consumes them.
module bp_be_idiv_radix2 #(
    parameter int unsigned width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] dividend_i,
    input  logic [width_p-1:0] divisor_i,
    input  logic               signed_div_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] quotient_o,
    output logic [width_p-1:0] remainder_o,
    output logic               v_o,
    input  logic               yumi_i
);

    localparam int unsigned W     = width_p;
    localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             r_state;
    logic               r_ready;
    logic               r_v;
    logic [W-1:0]       r_quotient;
    logic [W-1:0]       r_remainder;
    logic [CNT_W-1:0]   r_cnt;
    logic [W-1:0]       r_rem;
    logic [W-1:0]       r_quo;
    logic [W-1:0]       r_dvs;
    logic [W-1:0]       r_raw;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div_zero;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [W-1:0]       w_a_abs;
    logic [W-1:0]       w_b_abs;
    logic [W:0]         w_shift;
    logic               w_ge;
    logic [W-1:0]       w_diff;
    logic [W-1:0]       w_rem_next;
    logic [W-1:0]       w_q_fix;
    logic [W-1:0]       w_r_fix;

    // Operand magnitudes and sign bookkeeping at accept time
    assign w_a_neg = signed_div_i & dividend_i[W-1];
    assign w_b_neg = signed_div_i & divisor_i[W-1];
    assign w_a_abs = w_a_neg ? (W'(0) - dividend_i) : dividend_i;
    assign w_b_abs = w_b_neg ? (W'(0) - divisor_i)  : divisor_i;

    // One restoring step: W+1-bit shifted partial remainder vs divisor.
    // The difference always fits in W bits because it is below the divisor.
    assign w_shift    = {r_rem, r_quo[W-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_diff     = w_shift[W-1:0] - r_dvs;
    assign w_rem_next = w_ge ? w_diff : w_shift[W-1:0];

    assign w_q_fix = r_neg_q ? (W'(0) - r_quo) : r_quo;
    assign w_r_fix = r_neg_r ? (W'(0) - r_rem) : r_rem;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_v         <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_ready && v_i) begin
                        r_ready    <= 1'b0;
                        r_quo      <= w_a_abs;
                        r_dvs      <= w_b_abs;
                        r_rem      <= '0;
                        r_raw      <= dividend_i;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div_zero <= (divisor_i == '0);
                        r_cnt      <= '0;
                        r_state    <= S_CALC;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[W-2:0], w_ge};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(W - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Divide-by-zero returns all ones and the untouched dividend
                    r_quotient  <= r_div_zero ? '1    : w_q_fix;
                    r_remainder <= r_div_zero ? r_raw : w_r_fix;
                    r_v         <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (yumi_i) begin
                        r_v     <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o     = r_ready;
    assign v_o         = r_v;
    assign quotient_o  = r_quotient;
    assign remainder_o = r_remainder;

endmodule
